// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, per-button stability counter,
// debounced level, one-cycle press/release strobes and a press-driven toggle.
module btn_debounce #(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_toggle
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] s1;
  logic [N_BTN-1:0] s2;
  logic [CW-1:0]    cnt [N_BTN];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1          <= '0;
      s2          <= '0;
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      btn_toggle  <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1          <= btn;
      s2          <= s1;
      btn_press   <= '0;
      btn_release <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        // Any sample matching the accepted level restarts the stability window.
        if (s2[i] == btn_level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          cnt[i]       <= '0;
          btn_level[i] <= s2[i];
          if (s2[i]) begin
            btn_press[i]  <= 1'b1;
            btn_toggle[i] <= ~btn_toggle[i];
          end else begin
            btn_release[i] <= 1'b1;
          end
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed scenarios plus random bouncing, scored
// cycle by cycle against a run-length reference model.
module tb_btn_debounce;
  localparam int N = 3;
  localparam int D = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn = '0;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_toggle;

  btn_debounce #(.N_BTN(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .btn(btn),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_toggle(btn_toggle)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int press_seen [N];

  logic [W-1:0] exp_q [$];

  // reference model: raw sample history, mismatch run length per button
  logic [N-1:0] hist [$];
  logic [N-1:0] m_lvl = '0;
  logic [N-1:0] m_tog = '0;
  int           run [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // one clock: drive inputs, advance the model, queue the expected outputs
  task automatic cycle(input logic [N-1:0] b, input logic r);
    logic [N-1:0] seen, pr, rl;
    btn = b;
    rst = r;
    @(posedge clk);
    pr = '0;
    rl = '0;
    if (r) begin
      hist.delete();
      m_lvl = '0;
      m_tog = '0;
      for (int i = 0; i < N; i++) run[i] = 0;
    end else begin
      // the stability logic sees the raw value captured two edges earlier
      seen = (hist.size() >= 2) ? hist[hist.size()-2] : '0;
      hist.push_back(b);
      if (hist.size() > 2) void'(hist.pop_front());
      for (int i = 0; i < N; i++) begin
        if (seen[i] != m_lvl[i]) run[i]++;
        else run[i] = 0;
        if (run[i] == D) begin
          run[i]   = 0;
          m_lvl[i] = seen[i];
          if (seen[i]) begin
            pr[i]    = 1'b1;
            m_tog[i] = ~m_tog[i];
          end else begin
            rl[i] = 1'b1;
          end
        end
      end
    end
    exp_q.push_back({m_lvl, pr, rl, m_tog});
    #1;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < N; i++) press_seen[i] = 0;
  endtask

  // monitor: compare every presented output cycle against the queued model
  always @(negedge clk) begin
    logic [W-1:0] e;
    for (int i = 0; i < N; i++) if (btn_press[i] === 1'b1) press_seen[i]++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("outputs", 32'({btn_level, btn_press, btn_release, btn_toggle}), 32'(e));
      if ((btn_press & btn_release) !== '0)
        chk("strobe_exclusive", 32'(btn_press & btn_release), 32'd0);
    end
  end

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] cur;
    int           hold [N];
    clear_counts();
    for (int i = 0; i < N; i++) run[i] = 0;

    cycle('0, 1'b1);
    cycle('0, 1'b1);

    // quiet after reset
    repeat (10) cycle(3'b000, 1'b0);
    settle();
    chk("reset_level", 32'(btn_level), 32'd0);

    // clean press and release of button 0
    clear_counts();
    repeat (10) cycle(3'b001, 1'b0);
    repeat (10) cycle(3'b000, 1'b0);
    settle();
    chk("clean_press_count", 32'(press_seen[0]), 32'd1);
    chk("toggle_after_release", 32'(btn_toggle), 32'b001);

    // bounces on button 1 shorter than the window
    clear_counts();
    repeat (4) begin
      repeat (3) cycle(3'b010, 1'b0);
      repeat (2) cycle(3'b000, 1'b0);
    end
    repeat (10) cycle(3'b000, 1'b0);
    settle();
    chk("bounce_press_count", 32'(press_seen[1]), 32'd0);
    chk("bounce_toggle", 32'(btn_toggle[1]), 32'd0);

    // button 2 chatters then settles high
    clear_counts();
    for (int k = 0; k < 5; k++) cycle((k % 2 == 0) ? 3'b100 : 3'b000, 1'b0);
    repeat (10) cycle(3'b100, 1'b0);
    settle();
    chk("settle_press_count", 32'(press_seen[2]), 32'd1);
    chk("settle_toggle", 32'(btn_toggle[2]), 32'd1);
    repeat (10) cycle(3'b000, 1'b0);

    // simultaneous buttons
    clear_counts();
    repeat (10) cycle(3'b101, 1'b0);
    repeat (10) cycle(3'b111, 1'b0);
    repeat (10) cycle(3'b000, 1'b0);
    settle();
    chk("simul_press_b1", 32'(press_seen[1]), 32'd1);

    // reset mid-count with buttons held through it
    clear_counts();
    repeat (4) cycle(3'b111, 1'b0);
    settle();
    chk("pre_reset_presses", 32'(press_seen[0] + press_seen[1] + press_seen[2]), 32'd0);
    cycle(3'b111, 1'b1);
    repeat (10) cycle(3'b111, 1'b0);
    settle();
    chk("post_reset_presses", 32'(press_seen[0] + press_seen[1] + press_seen[2]), 32'd3);
    chk("post_reset_toggle", 32'(btn_toggle), 32'b111);

    // random bouncing with occasional resets
    cur = '0;
    for (int i = 0; i < N; i++) hold[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          cur[i]  = 1'($urandom_range(0, 1));
          hold[i] = $urandom_range(1, 8);
        end
        hold[i]--;
      end
      cycle(cur, $urandom_range(0, 99) == 0);
    end

    settle();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Conditions the raw, asynchronous push-button inputs of the board before they reach LED and control logic. Each button passes through a two-flop synchronizer and a per-button stability counter. The block produces a clean debounced level, single-cycle press and release strobes, and a per-button toggle state. It sits between the `btn` pins and any logic that consumes button state, so downstream blocks never see metastability or contact bounce.

## Interface
Parameters:
- `N_BTN`, default 3: number of buttons.
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required to accept a new level. Must be ≥ 2. The counter width is `$clog2(DEBOUNCE_CYCLES)`.

Ports:
- `clk`, input, 1: the single clock. All state changes on its rising edge.
- `rst`, input, 1: reset. Synchronous and active-high.
- `btn`, input, N_BTN: raw button pins. Asynchronous to `clk`, active-high, may bounce.
- `btn_level`, output, N_BTN: debounced level per button.
- `btn_press`, output, N_BTN: one-cycle strobe when `btn_level[i]` goes 0→1.
- `btn_release`, output, N_BTN: one-cycle strobe when `btn_level[i]` goes 1→0.
- `btn_toggle`, output, N_BTN: inverts on every accepted press of button i.

## Operation
Each bit i is fully independent and uses the same logic.
- **Synchronizer:** `s1[i] <= btn[i]`, then `s2[i] <= s1[i]`. No logic acts on `s1`.
- **Stability counter `cnt[i]`, on each edge, outside reset:**
  - If `s2[i] == btn_level[i]`, then `cnt[i] <= 0`. Any bounce back to the current level restarts the count.
  - Else if `cnt[i] == DEBOUNCE_CYCLES-1`:
    - `btn_level[i] <= s2[i]` and `cnt[i] <= 0`.
    - Pulse `btn_press[i]` if the new level is 1, or `btn_release[i]` if it is 0.
  - Otherwise `cnt[i] <= cnt[i]+1`.
- **Toggle:** `btn_toggle[i]` inverts on the same edge where `btn_press[i]` is registered high. Release does not affect it.
- **Strobe exclusivity:** `btn_press` and `btn_release` are registered outputs and last exactly one cycle. They are never both high for the same bit.
- **Reset** (`rst` high at an edge): clears `s1`, `s2`, `cnt`, `btn_level`, `btn_press`, `btn_release` and `btn_toggle` to 0.
  - Reset applied mid-count discards the partial count.
  - Reset has priority over every other update.
- **Button held through reset:** after `rst` deasserts, the button is treated as a fresh 0→1 transition and produces one press after the normal latency.
- **Simultaneous events:** several buttons may change on the same edge; each produces its own strobes independently and on the same edge if their timing is identical.

## Timing
- **Reset values:** all outputs are 0.
- **Acceptance latency:** `btn_level[i]` changes on rising edge number DEBOUNCE_CYCLES+2. Edge 1 is the first edge that samples the new raw value into `s1`, and the raw value must hold through every edge up to that point. Breakdown:
  - 2 edges for the synchronizer.
  - DEBOUNCE_CYCLES-1 counting edges.
  - 1 commit edge.
- The matching `btn_press` or `btn_release` strobe is high during the cycle following the commit edge, coincident with the new `btn_level`. It drops on the next edge.
- **Rejected glitches:** a raw pulse that holds fewer than DEBOUNCE_CYCLES consecutive `s2` cycles is rejected. There is no strobe, and `btn_level` and `btn_toggle` are unchanged.
- **Throughput:** the minimum spacing between two accepted transitions of one button is DEBOUNCE_CYCLES cycles. A new transition may begin counting on the edge immediately after a commit.
- **Counter bounds:** `cnt` never exceeds DEBOUNCE_CYCLES-1 and never wraps.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, N_BTN=3, and `rst` held for 2 cycles at start. Acceptance latency is therefore 6 edges.
1. **Reset state:** hold `btn`=3'b000 for 10 cycles → all outputs 0, no strobes.
2. **Clean press:** `btn`=3'b001 held → `btn_level`=3'b001 and `btn_press`=3'b001 for exactly one cycle, 6 edges after the first sampling edge. `btn_toggle`=3'b001. Then set `btn`=3'b000 → `btn_release`=3'b001 after 6 edges, `btn_toggle` stays 3'b001.
3. **Bounce rejection:** `btn[1]` high for 3 cycles, low for 2, repeated 4 times, then low → `btn_level`, `btn_press` and `btn_toggle` for bit 1 stay 0 throughout.
4. **Bounce then settle:** `btn[2]` toggles every cycle for 5 cycles, then holds 1 → exactly one `btn_press[2]` strobe, 6 edges after the last raw change. `btn_toggle[2]` becomes 1.
5. **Simultaneous buttons:** `btn`=3'b101 changes on one edge → `btn_press`=3'b101 in the same single cycle. Follow with `btn`=3'b111 → `btn_press`=3'b010 only.
6. **Reset mid-operation:** `btn`=3'b111 for 4 cycles, assert `rst` for 1 cycle, keep `btn` high → no strobe before reset. After reset, `btn_press`=3'b111 exactly 6 edges after the first post-reset edge, and `btn_toggle`=3'b111.
